// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch/jump squash, mul/div and dmem wait.
// Zero-latency control (outputs combinational from state and inputs); stall_count is registered.
module pipeline_hazard_ctrl #(
    parameter int MDU_CYCLES = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt_addr,
    input  logic             ex_branch_taken,
    input  logic             ex_mdu_start,
    input  logic             mem_access,
    input  logic             mem_ready,
    input  logic             stat_clr,
    output logic             pc_wr_en,
    output logic             if_id_wr_en,
    output logic             if_id_flush,
    output logic             id_ex_wr_en,
    output logic             id_ex_flush,
    output logic             ex_mem_wr_en,
    output logic             ex_mem_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic       MDU_EN   = (MDU_CYCLES > 1);
    // The start cycle is spent in RUN, so the MDU state only covers the remaining cycles.
    localparam logic [3:0] CNT_INIT = (MDU_CYCLES > 1) ? 4'(MDU_CYCLES - 2) : 4'd0;

    state_t     state_q, state_d;
    logic [3:0] mdu_cnt_q, mdu_cnt_d;
    logic       freeze, mdu_stall;
    logic       mem_stall, mdu_go, load_use;

    assign mem_stall = mem_access & ~mem_ready;
    assign mdu_go    = MDU_EN & ex_mdu_start;
    assign load_use  = ex_mem_read & (ex_rt_addr != 5'd0) &
                       ((id_uses_rs & (id_rs_addr == ex_rt_addr)) |
                        (id_uses_rt & (id_rt_addr == ex_rt_addr)));

    always_comb begin
        state_d   = ST_RUN;
        mdu_cnt_d = mdu_cnt_q;
        freeze    = 1'b0;
        mdu_stall = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    freeze  = 1'b1;
                    state_d = ST_MEM_WAIT;
                end else if (mdu_go) begin
                    mdu_stall = 1'b1;
                    mdu_cnt_d = CNT_INIT;
                    state_d   = ST_MDU;
                end
            end
            ST_MDU: begin
                if (mdu_cnt_q != 4'd0) begin
                    mdu_stall = 1'b1;
                    mdu_cnt_d = mdu_cnt_q - 4'd1;
                    state_d   = ST_MDU;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready) begin
                    freeze  = 1'b1;
                    state_d = ST_MEM_WAIT;
                end else if (mdu_go) begin
                    mdu_stall = 1'b1;
                    mdu_cnt_d = CNT_INIT;
                    state_d   = ST_MDU;
                end
            end
            default: begin
                // Unreachable encoding: behave like RUN for one cycle, then recover.
                freeze    = mem_stall;
                mdu_stall = ~mem_stall & mdu_go;
            end
        endcase
    end

    always_comb begin
        pc_wr_en     = 1'b1;
        if_id_wr_en  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_wr_en  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_wr_en = 1'b1;
        ex_mem_flush = 1'b0;
        if (!reset) begin
            pc_wr_en     = 1'b0;
            if_id_wr_en  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_wr_en  = 1'b0;
            id_ex_flush  = 1'b1;
            ex_mem_wr_en = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (freeze) begin
            pc_wr_en     = 1'b0;
            if_id_wr_en  = 1'b0;
            id_ex_wr_en  = 1'b0;
            ex_mem_wr_en = 1'b0;
        end else if (mdu_stall) begin
            pc_wr_en     = 1'b0;
            if_id_wr_en  = 1'b0;
            id_ex_wr_en  = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (load_use) begin
            pc_wr_en     = 1'b0;
            if_id_wr_en  = 1'b0;
            id_ex_flush  = 1'b1;
        end else if (id_jump) begin
            if_id_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            mdu_cnt_q   <= 4'd0;
            stall_count <= '0;
        end else begin
            state_q   <= state_d;
            mdu_cnt_q <= mdu_cnt_d;
            if (stat_clr)
                stall_count <= '0;
            else if (!pc_wr_en && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + 1'b1;
        end
    end

    assign state = state_q;

endmodule
